// File: rtl/period_meter_if.sv
// Signal bundle between a period_meter and whatever drives/reads it.
// The slave modport is the meter's view; the master modport is the source/readout side.
interface period_meter_if #(
  parameter int WIDTH = 10
);
  logic             enable_n;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             overflow;

  modport master (
    output enable_n, sig_in,
    input  period, high_time, valid, overflow
  );

  modport slave (
    input  enable_n, sig_in,
    output period, high_time, valid, overflow
  );
endinterface

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// reporting one saturating result per full cycle of the wave.
module period_meter #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  period_meter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] MAX_CNT = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi_cnt;
  logic             r_sat;

  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;
  logic             r_overflow;
  logic             r_valid;

  logic w_start;
  logic w_capture;

  // Synchronizer runs regardless of enable so a stale level never looks like a fresh edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.sig_in};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Disable overrides everything, including a rise in the same cycle.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
    w_state_next = r_state;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    if (bus.enable_n) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_ARM;
        ST_ARM: begin
          if (w_rise) begin
            w_state_next = ST_MEASURE;
            w_start      = 1'b1;
          end
        end
        ST_MEASURE: begin
          w_capture = w_rise;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi_cnt <= '0;
      r_sat    <= 1'b0;
    end else if (bus.enable_n || r_state == ST_IDLE) begin
      r_cnt    <= '0;
      r_hi_cnt <= '0;
      r_sat    <= 1'b0;
    end else if (w_start || w_capture) begin
      // The rise cycle itself is the first cycle of the new period and is high.
      r_cnt    <= ONE;
      r_hi_cnt <= ONE;
      r_sat    <= 1'b0;
    end else if (r_state == ST_MEASURE) begin
      if (r_cnt == MAX_CNT) begin
        r_sat <= 1'b1;
      end else begin
        r_cnt <= r_cnt + ONE;
      end
      if (w_s && r_hi_cnt != MAX_CNT) begin
        r_hi_cnt <= r_hi_cnt + ONE;
      end
    end
  end

  // Results and valid update on the same edge, one cycle after the rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period    <= '0;
      r_high_time <= '0;
      r_overflow  <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_period    <= r_cnt;
        r_high_time <= r_hi_cnt;
        r_overflow  <= r_sat;
      end
    end
  end

  assign bus.period    = r_period;
  assign bus.high_time = r_high_time;
  assign bus.overflow  = r_overflow;
  assign bus.valid     = r_valid;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: waves are driven cycle-exactly, a negedge monitor
// records every valid pulse, and the main sequence asserts on what it recorded.
module tb_period_meter;

  localparam int WIDTH = 10;

  logic clk = 1'b0;
  logic reset;

  period_meter_if #(.WIDTH(WIDTH)) bus ();

  period_meter #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int cyc        = 0;
  int n_valid    = 0;
  int last_cyc   = 0;
  int prev_cyc   = 0;
  int last_period;
  int last_high;
  int last_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      n_valid     <= n_valid + 1;
      prev_cyc    <= last_cyc;
      last_cyc    <= cyc;
      last_period <= int'(bus.period);
      last_high   <= int'(bus.high_time);
      last_ovf    <= int'(bus.overflow);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input int h, input int l);
    bus.sig_in = 1'b1;
    cyc_wait(h);
    bus.sig_in = 1'b0;
    cyc_wait(l);
  endtask

  task automatic check_last(input string tag, input int p, input int h, input int o);
    check({tag, "_period"}, last_period, p);
    check({tag, "_high"}, last_high, h);
    check({tag, "_ovf"}, last_ovf, o);
  endtask

  int v;

  initial begin
    reset        = 1'b1;
    bus.enable_n = 1'b1;
    bus.sig_in   = 1'b0;
    cyc_wait(2);
    check("rst_period", bus.period, 0);
    check("rst_high", bus.high_time, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_ovf", bus.overflow, 0);
    reset        = 1'b0;
    bus.enable_n = 1'b0;
    cyc_wait(2);

    // 20/10 wave: first rise only arms
    wave(10, 10);
    check("t1_first_rise_no_valid", n_valid, 0);
    repeat (4) wave(10, 10);
    check("t1_valid_count", n_valid, 4);
    check_last("t1", 20, 10, 0);
    check("t1_spacing", last_cyc - prev_cyc, 20);

    // 16/4, then a cut-short 6/4 cycle, then 6/3
    wave(4, 12);
    check_last("t2_prev20", 20, 10, 0);
    repeat (2) wave(4, 12);
    check_last("t2_16_4", 16, 4, 0);
    wave(4, 2);
    check_last("t2_before_mix", 16, 4, 0);
    wave(3, 3);
    check_last("t2_mixed", 6, 4, 0);
    repeat (3) wave(3, 3);
    check_last("t2_6_3", 6, 3, 0);
    check("t2_spacing", last_cyc - prev_cyc, 6);

    // width boundary: 1023 exact, then 1500 saturates
    wave(500, 523);
    check_last("t3_prev6", 6, 3, 0);
    wave(500, 1000);
    check_last("t3_1023", 1023, 500, 0);
    wave(10, 10);
    check_last("t3_1500", 1023, 500, 1);
    repeat (2) wave(10, 10);
    check_last("t3_recover", 20, 10, 0);

    // enable_n high for 30 cycles mid-period
    bus.sig_in = 1'b1;
    cyc_wait(5);
    v = n_valid;
    bus.enable_n = 1'b1;
    cyc_wait(5);
    bus.sig_in = 1'b0;
    cyc_wait(10);
    bus.sig_in = 1'b1;
    cyc_wait(10);
    bus.sig_in = 1'b0;
    cyc_wait(5);
    check("t4_no_valid_disabled", n_valid, v);
    check("t4_hold_period", bus.period, 20);
    check("t4_hold_high", bus.high_time, 10);
    bus.enable_n = 1'b0;
    cyc_wait(3);
    wave(7, 7);
    check("t4_rearm_no_valid", n_valid, v);
    wave(7, 7);
    check("t4_after_rearm_count", n_valid, v + 1);
    check_last("t4_after_rearm", 14, 7, 0);

    // enable_n=1 in exactly the rise cycle
    cyc_wait(5);
    v = n_valid;
    bus.sig_in = 1'b1;
    cyc_wait(2);
    bus.enable_n = 1'b1;
    cyc_wait(1);
    bus.enable_n = 1'b0;
    cyc_wait(10);
    bus.sig_in = 1'b0;
    cyc_wait(10);
    check("t6_no_valid", n_valid, v);
    check("t6_period_held", bus.period, 14);
    wave(7, 7);
    check("t6_went_idle_rearm", n_valid, v);
    wave(7, 7);
    check("t6_resume_count", n_valid, v + 1);
    check_last("t6_resume", 14, 7, 0);

    // async reset between clk edges during MEASURE
    repeat (2) wave(10, 10);
    check_last("t5_pre", 20, 10, 0);
    bus.sig_in = 1'b1;
    cyc_wait(4);
    #3;
    reset = 1'b1;
    #1;
    check("t5_async_period", bus.period, 0);
    check("t5_async_high", bus.high_time, 0);
    check("t5_async_valid", bus.valid, 0);
    check("t5_async_ovf", bus.overflow, 0);
    bus.sig_in = 1'b0;
    cyc_wait(3);
    reset = 1'b0;
    cyc_wait(2);
    v = n_valid;
    wave(10, 10);
    check("t5_first_rise_no_valid", n_valid, v);
    check("t5_period_still0", bus.period, 0);
    wave(10, 10);
    check("t5_second_rise_count", n_valid, v + 1);
    check_last("t5_resume", 20, 10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
